pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/rvga_types.sv | 29 ++
 rtl/pipeline_hazard_ctrl_if.sv | 44 ++++
 rtl/dff.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rvga_types.sv
// Shared types for the pipeline hazard controller: register address, hazard FSM states,
// and the per-stage shadow entry that mirrors what the datapath holds.
package rvga_types;

    typedef logic [4:0] rvga_reg_addr;

    typedef enum logic [1:0] {
        StRun,
        StLdUse,
        StMemWait
    } hazard_state_e;

    typedef struct packed {
        logic         v;
        rvga_reg_addr rd;
        logic         rd_w_v;
        logic         ld_v;
        logic         mem_v;
    } shadow_entry_t;

    localparam int unsigned ShadowWidth = $bits(shadow_entry_t);

    // True when a source that is actually read names a written, non-x0 destination.
    function automatic logic src_match(input rvga_reg_addr rs, input logic rs_use,
                                       input rvga_reg_addr rd, input logic rd_w_v);
        return rs_use & rd_w_v & (rd != '0) & (rs == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/branch/memory inputs and stall/forward outputs of the hazard controller.
interface pipeline_hazard_ctrl_if;
    import rvga_types::*;

    logic         decode_v_i;
    rvga_reg_addr decode_rs1_i;
    rvga_reg_addr decode_rs2_i;
    logic         decode_rs1_use_i;
    logic         decode_rs2_use_i;
    rvga_reg_addr decode_rd_i;
    logic         decode_rd_w_v_i;
    logic         decode_ld_v_i;
    logic         decode_mem_v_i;
    logic         br_taken_i;
    logic         dmem_ready_i;

    logic         front_stall_v_o;
    logic         back_stall_v_o;
    logic         bubble_v_o;
    logic         flush_v_o;
    logic         forward_memory_execute_rs1_v_o;
    logic         forward_memory_execute_rs2_v_o;
    logic         forward_writeback_execute_rs1_v_o;
    logic         forward_writeback_execute_rs2_v_o;

    modport master (
        output decode_v_i, decode_rs1_i, decode_rs2_i, decode_rs1_use_i, decode_rs2_use_i,
               decode_rd_i, decode_rd_w_v_i, decode_ld_v_i, decode_mem_v_i, br_taken_i,
               dmem_ready_i,
        input  front_stall_v_o, back_stall_v_o, bubble_v_o, flush_v_o,
               forward_memory_execute_rs1_v_o, forward_memory_execute_rs2_v_o,
               forward_writeback_execute_rs1_v_o, forward_writeback_execute_rs2_v_o
    );

    modport slave (
        input  decode_v_i, decode_rs1_i, decode_rs2_i, decode_rs1_use_i, decode_rs2_use_i,
               decode_rd_i, decode_rd_w_v_i, decode_ld_v_i, decode_mem_v_i, br_taken_i,
               dmem_ready_i,
        output front_stall_v_o, back_stall_v_o, bubble_v_o, flush_v_o,
               forward_memory_execute_rs1_v_o, forward_memory_execute_rs2_v_o,
               forward_writeback_execute_rs1_v_o, forward_writeback_execute_rs2_v_o
    );

endinterface

// File: rtl/dff.sv
// Enable flop with synchronous active-high clear.
module dff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             w_v_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] data_q;

    // Clear on reset, otherwise capture only when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (w_v_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: tracks ex/mem/wb destinations in shadow entries and produces
// stall, bubble, flush and registered forwarding selects for the execute stage.
module pipeline_hazard_ctrl
    import rvga_types::*;
(
    input logic                 clk_i,
    input logic                 rst_i,
    pipeline_hazard_ctrl_if.slave hz
);

    hazard_state_e state_q, state_d;
    shadow_entry_t ex_d, ex_q, mem_q, wb_q;
    logic [3:0]    fwd_d, fwd_q;
    logic          mem_wait, ld_use;
    logic          front_stall, back_stall, bubble, flush;

    // Hazard detection from shadows and current decode.
    always_comb begin
        mem_wait = mem_q.v & mem_q.mem_v & ~hz.dmem_ready_i;
        // Bubble already inserted while in LdUse, so never stall twice for one load.
        ld_use   = ex_q.v & ex_q.ld_v & hz.decode_v_i & (state_q != StLdUse) &
                   (src_match(hz.decode_rs1_i, hz.decode_rs1_use_i, ex_q.rd, 1'b1) |
                    src_match(hz.decode_rs2_i, hz.decode_rs2_use_i, ex_q.rd, 1'b1));
    end

    // Next state and stall outputs; memory wait beats branch flush beats load-use.
    always_comb begin
        state_d     = StRun;
        front_stall = 1'b0;
        back_stall  = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        if (!rst_i) begin
            if (mem_wait) begin
                state_d     = StMemWait;
                front_stall = 1'b1;
                back_stall  = 1'b1;
            end else if (hz.br_taken_i) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (ld_use) begin
                state_d     = StLdUse;
                front_stall = 1'b1;
                bubble      = 1'b1;
            end
        end
    end

    // Hazard state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Execute shadow loads decode, or an empty entry on bubble or invalid decode.
    always_comb begin
        ex_d = '0;
        if (hz.decode_v_i && !bubble) begin
            ex_d.v      = 1'b1;
            ex_d.rd     = hz.decode_rd_i;
            ex_d.rd_w_v = hz.decode_rd_w_v_i;
            ex_d.ld_v   = hz.decode_ld_v_i;
            ex_d.mem_v  = hz.decode_mem_v_i;
        end
    end

    // Forward selects computed against the instructions decode will follow in execute.
    always_comb begin
        fwd_d = '0;
        if (!bubble) begin
            fwd_d[3] = src_match(hz.decode_rs1_i, hz.decode_rs1_use_i, ex_q.rd, ex_q.rd_w_v);
            fwd_d[2] = src_match(hz.decode_rs2_i, hz.decode_rs2_use_i, ex_q.rd, ex_q.rd_w_v);
            fwd_d[1] = src_match(hz.decode_rs1_i, hz.decode_rs1_use_i, mem_q.rd, mem_q.rd_w_v);
            fwd_d[0] = src_match(hz.decode_rs2_i, hz.decode_rs2_use_i, mem_q.rd, mem_q.rd_w_v);
        end
    end

    dff #(.Width(ShadowWidth)) u_ex_dff (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .w_v_i  (~back_stall),
        .data_i (ex_d),
        .data_o (ex_q)
    );

    dff #(.Width(ShadowWidth)) u_mem_dff (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .w_v_i  (~back_stall),
        .data_i (ex_q),
        .data_o (mem_q)
    );

    dff #(.Width(ShadowWidth)) u_wb_dff (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .w_v_i  (~back_stall),
        .data_i (mem_q),
        .data_o (wb_q)
    );

    dff #(.Width(4)) u_fwd_dff (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .w_v_i  (~back_stall),
        .data_i (fwd_d),
        .data_o (fwd_q)
    );

    // Writeback entry completes the pipeline picture but feeds no hazard today.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    assign hz.front_stall_v_o                   = front_stall;
    assign hz.back_stall_v_o                    = back_stall;
    assign hz.bubble_v_o                        = bubble;
    assign hz.flush_v_o                         = flush;
    assign hz.forward_memory_execute_rs1_v_o    = fwd_q[3];
    assign hz.forward_memory_execute_rs2_v_o    = fwd_q[2];
    assign hz.forward_writeback_execute_rs1_v_o = fwd_q[1];
    assign hz.forward_writeback_execute_rs2_v_o = fwd_q[0];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios with pinned literal
// expectations, then randomized traffic, all checked against a stage-array model.
module tb_pipeline_hazard_ctrl;
    import rvga_types::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    // Model: stage 0 = execute, 1 = memory, 2 = writeback.
    logic       m_v[3];
    logic [4:0] m_rd[3];
    logic       m_w[3];
    logic       m_ld[3];
    logic       m_mem[3];
    logic       m_fmem[2];
    logic       m_fwb[2];

    // Literal expectations pinned by the directed sequence for the current cycle.
    string      pin_tag  = "";
    logic [7:0] pin_mask = '0;
    logic [7:0] pin_val  = '0;

    logic [3:0] exp_c;
    logic [7:0] act;
    logic [7:0] model_vec;

    assign act = {hz.front_stall_v_o, hz.back_stall_v_o, hz.bubble_v_o, hz.flush_v_o,
                  hz.forward_memory_execute_rs1_v_o, hz.forward_memory_execute_rs2_v_o,
                  hz.forward_writeback_execute_rs1_v_o, hz.forward_writeback_execute_rs2_v_o};

    // Control rules in priority order: {front_stall, back_stall, bubble, flush}.
    function automatic logic [3:0] exp_ctrl();
        logic reads_ex;
        if (rst) return 4'b0000;
        if (m_v[1] && m_mem[1] && !hz.dmem_ready_i) return 4'b1100;
        if (hz.br_taken_i) return 4'b0011;
        reads_ex = (hz.decode_rs1_use_i && hz.decode_rs1_i == m_rd[0]) ||
                   (hz.decode_rs2_use_i && hz.decode_rs2_i == m_rd[0]);
        if (m_v[0] && m_ld[0] && m_rd[0] != 5'd0 && hz.decode_v_i && reads_ex) return 4'b1010;
        return 4'b0000;
    endfunction

    function automatic logic hit(input logic [4:0] rs, input logic use_v, input int st);
        return use_v && m_w[st] && (m_rd[st] != 5'd0) && (rs == m_rd[st]);
    endfunction

    function automatic string out_name(input int i);
        case (i)
            7: return "front_stall";
            6: return "back_stall";
            5: return "bubble";
            4: return "flush";
            3: return "fwd_mem_rs1";
            2: return "fwd_mem_rs2";
            1: return "fwd_wb_rs1";
            default: return "fwd_wb_rs2";
        endcase
    endfunction

    always_comb exp_c = exp_ctrl();
    assign model_vec = {exp_c, m_fmem[0], m_fmem[1], m_fwb[0], m_fwb[1]};

    // Model advance at each rising edge.
    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_v[i] <= 1'b0; m_rd[i] <= 5'd0; m_w[i] <= 1'b0;
                m_ld[i] <= 1'b0; m_mem[i] <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                m_fmem[i] <= 1'b0; m_fwb[i] <= 1'b0;
            end
        end else if (!exp_c[2]) begin
            for (int i = 2; i > 0; i--) begin
                m_v[i] <= m_v[i-1]; m_rd[i] <= m_rd[i-1]; m_w[i] <= m_w[i-1];
                m_ld[i] <= m_ld[i-1]; m_mem[i] <= m_mem[i-1];
            end
            if (!exp_c[1] && hz.decode_v_i) begin
                m_v[0] <= 1'b1; m_rd[0] <= hz.decode_rd_i; m_w[0] <= hz.decode_rd_w_v_i;
                m_ld[0] <= hz.decode_ld_v_i; m_mem[0] <= hz.decode_mem_v_i;
            end else begin
                m_v[0] <= 1'b0; m_rd[0] <= 5'd0; m_w[0] <= 1'b0;
                m_ld[0] <= 1'b0; m_mem[0] <= 1'b0;
            end
            m_fmem[0] <= !exp_c[1] && hit(hz.decode_rs1_i, hz.decode_rs1_use_i, 0);
            m_fmem[1] <= !exp_c[1] && hit(hz.decode_rs2_i, hz.decode_rs2_use_i, 0);
            m_fwb[0]  <= !exp_c[1] && hit(hz.decode_rs1_i, hz.decode_rs1_use_i, 1);
            m_fwb[1]  <= !exp_c[1] && hit(hz.decode_rs2_i, hz.decode_rs2_use_i, 1);
        end
    end

    task automatic check(input string name, input logic actual, input logic expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every output against the model, plus any pinned literals.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 8; i++) begin
                check(out_name(i), act[i], model_vec[i]);
                if (pin_mask[i]) check({pin_tag, ".", out_name(i)}, act[i], pin_val[i]);
            end
        end
    end

    task automatic set_in(input int v, input int rs1, input int u1, input int rs2, input int u2,
                          input int rd, input int w, input int ld, input int mem,
                          input int br, input int rdy);
        hz.decode_v_i       = (v != 0);
        hz.decode_rs1_i     = 5'(rs1);
        hz.decode_rs1_use_i = (u1 != 0);
        hz.decode_rs2_i     = 5'(rs2);
        hz.decode_rs2_use_i = (u2 != 0);
        hz.decode_rd_i      = 5'(rd);
        hz.decode_rd_w_v_i  = (w != 0);
        hz.decode_ld_v_i    = (ld != 0);
        hz.decode_mem_v_i   = (mem != 0);
        hz.br_taken_i       = (br != 0);
        hz.dmem_ready_i     = (rdy != 0);
    endtask

    task automatic idle(input int rdy);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        pin_mask = '0;
    endtask

    task automatic pin(input string tag, input logic [7:0] mask, input logic [7:0] val);
        pin_tag  = tag;
        pin_mask = mask;
        pin_val  = val;
    endtask

    initial begin
        rst = 1'b1;
        idle(1);
        pin("reset", 8'hFF, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // lw x5 then add x6,x5,x1: one stall+bubble, then writeback forward on rs1.
        cyc(); rst = 1'b0; set_in(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, 1);
        pin("lu_pre", 8'hF0, 8'h00);
        cyc(); set_in(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1);
        pin("lu_stall", 8'hF0, 8'b1010_0000);
        cyc(); pin("lu_release", 8'hF0, 8'h00);
        cyc(); idle(1); pin("lu_fwd", 8'h0F, 8'b0000_0010);

        // add x5 then sub x7,x1,x5: no stall, memory forward on rs2.
        cyc(); set_in(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 1); pin("fw_pre", 8'hF0, 8'h00);
        cyc(); set_in(1, 1, 1, 5, 1, 7, 1, 0, 0, 0, 1); pin("fw_nostall", 8'hF0, 8'h00);
        cyc(); idle(1); pin("fw_mem", 8'h0F, 8'b0000_0100);

        // Load stuck in memory for three cycles while a writeback forward is live.
        cyc(); set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1);
        cyc(); set_in(1, 4, 1, 0, 0, 3, 1, 1, 1, 0, 1); pin("mw_pre", 8'hF0, 8'h00);
        cyc(); set_in(1, 4, 1, 0, 1, 10, 1, 0, 0, 0, 1); pin("mw_setup", 8'hF0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            cyc(); idle(0); pin("mw_wait", 8'hFF, 8'b1100_0010);
        end
        cyc(); idle(1); pin("mw_release", 8'hFF, 8'b0000_0010);

        // Taken branch while a load-use is pending: flush wins, no extra stall.
        cyc(); set_in(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, 1);
        cyc(); set_in(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 1); pin("br_flush", 8'hF0, 8'b0011_0000);
        cyc(); idle(1); pin("br_after", 8'hF0, 8'h00);

        // lw x0 and a consumer of x0: x0 never matches.
        cyc(); set_in(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
        cyc(); set_in(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 1); pin("x0_nostall", 8'hF0, 8'h00);
        cyc(); idle(1); pin("x0_nofwd", 8'h0F, 8'h00);

        // Reset in the middle of a memory wait.
        cyc(); set_in(1, 0, 0, 0, 0, 2, 1, 1, 1, 0, 1);
        cyc(); idle(1);
        cyc(); idle(0); pin("rst_wait", 8'h40, 8'h40);
        cyc(); rst = 1'b1; set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        pin("rst_mid", 8'hFF, 8'h00);
        cyc(); rst = 1'b0; idle(0); pin("rst_after", 8'hFF, 8'h00);

        // Randomized traffic against the model; small register range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            int ld, mem;
            cyc();
            rst = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            mem = (ld != 0 || $urandom_range(0, 4) == 0) ? 1 : 0;
            set_in(int'($urandom_range(0, 4) != 0), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3) != 0), ld, mem,
                   int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 3) != 0));
        end

        cyc(); rst = 1'b0; idle(1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
